// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Optional build macro SERIAL_ADDER_SUB_EN adds a sub input (a-b via ~b and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] b_ld;
  logic             cy, cy_ld;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             accept, last;

  // Operand B / carry load values; subtraction is a + ~b + 1.
  always_comb begin
    b_ld  = b;
    cy_ld = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_ld  = ~b;
      cy_ld = 1'b1;
    end
`endif
  end

  assign fa_s = a_sr[0] ^ b_sr[0] ^ cy;
  assign fa_c = (a_sr[0] & b_sr[0]) | (cy & (a_sr[0] ^ b_sr[0]));

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      cnt  <= '0;
      cy   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt <= '0;
        cy  <= cy_ld;
        sum <= '0;
      end else if (state == RUN) begin
        cnt <= last ? '0 : cnt + 1'b1;
        cy  <= fa_c;
        sum <= {fa_s, sum[WIDTH-1:1]};
        if (last) cout <= fa_c;
      end
    end
  end

  // Operand shift registers carry no reset: they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b_ld;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, random adds and an exhaustive 4-bit sweep.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start4 = 1'b0;
  logic [3:0]   a4 = '0, b4 = '0;
  logic         cin4 = 1'b0;
  logic         busy4, done4, cout4;
  logic [3:0]   sum4;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub = 1'b0;
  logic sub4 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} is the (W+1)-bit arithmetic result.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    a = x; b = y; cin = c; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 4*W) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    int lat;
    logic [W:0] e;
    e = model(x, y, c, s);
    launch(x, y, c, s);
    wait_done(0, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_result"}, 32'({cout, sum}), 32'(e));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int saw;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic [W:0] held;

    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);

    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Result must hold, done must not repeat.
    held = {cout, sum};
    tick(); tick(); tick();
    chk("hold_result", 32'({cout, sum}), 32'(held));
    chk("hold_done_low", 32'(done), 32'd0);

    // Start during RUN is ignored.
    launch(8'h5A, 8'h3C, 1'b0, 1'b0);
    tick();
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, lat);
    chk("ignored_latency", 32'(lat), 32'(W));
    chk("ignored_result", 32'({cout, sum}), 32'(9'h096));
    do_op("b2b", 8'h01, 8'h02, 1'b1, 1'b0);

    // Reset in the middle of RUN aborts the operation.
    launch(8'hA5, 8'h5A, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    saw = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw++;
    end
    chk("abort_no_done", 32'(saw), 32'd0);

    // Reset wins over a simultaneous start.
    a = 8'h33; b = 8'h44; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(busy), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op("random", ra, rb, rc, rs);
    end

    // Exhaustive 4-bit sweep, each start issued on the previous done cycle.
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int idx = 0; idx < 512; idx++) begin
      logic [4:0] e4;
      logic [8:0] cur;
      cur = 9'(idx);
      e4 = {1'b0, cur[7:4]} + {1'b0, cur[3:0]} + 5'(cur[8]);
      lat = 0;
      while (done4 !== 1'b1 && lat < 16) begin
        tick();
        lat++;
      end
      chk("exh_latency", 32'(lat), 32'd4);
      chk("exh_result", 32'({cout4, sum4}), 32'(e4));
      if (idx < 511) begin
        cur = 9'(idx + 1);
        a4 = cur[7:4]; b4 = cur[3:0]; cin4 = cur[8]; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
